// File: rtl/ir_rx_ctrl.sv
// ---------------------------------------------------------------------------
// ir_rx_ctrl
//   Sequencer for an external 11-bit IR receiver. Repeatedly pulses the
//   receiver reset (ARM), waits for a completed frame under a watchdog
//   (WAIT), captures it (CAPTURE) and buffers it in a 4-entry FIFO.
//
//   Optional feature (macro IR_RX_CTRL_MATCH_EN): when defined, only frames
//   equal to MATCH_CODE are buffered; other frames are dropped silently.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   1 = run receive cycles, 0 = return to IDLE
//   rx_done      in   receiver has a complete 11-bit frame
//   rx_data      in   [10:0] received frame
//   rx_rst_n     out  active-low receiver restart
//   frame_valid  out  FIFO head is valid
//   frame_ready  in   consumer accepts the head frame
//   frame_data   out  [10:0] FIFO head frame
//   busy         out  state is not IDLE
//   timeout_err  out  sticky watchdog expiry flag
//   overflow_err out  sticky dropped-frame flag
// ---------------------------------------------------------------------------
module ir_rx_ctrl #(
  parameter int unsigned ARM_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1200000,
  parameter logic [10:0] MATCH_CODE = 11'b00011110101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rx_done,
  input  logic [10:0] rx_data,
  output logic        rx_rst_n,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [10:0] frame_data,
  output logic        busy,
  output logic        timeout_err,
  output logic        overflow_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic [7:0]  ARM_LAST  = 8'(ARM_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  arm_cnt;
  logic [31:0] wait_cnt;

  logic        accept;
  logic        push_req;
  logic        push;
  logic        pop;

  logic [10:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

`ifdef IR_RX_CTRL_MATCH_EN
  assign accept = (rx_data == MATCH_CODE);
`else
  logic [10:0] unused_match_code;
  assign unused_match_code = MATCH_CODE;
  assign accept = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Control FSM; rx_rst_n and busy are registered alongside the state.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      arm_cnt     <= '0;
      wait_cnt    <= '0;
      rx_rst_n    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= ARM;
            arm_cnt  <= '0;
            rx_rst_n <= 1'b0;
            busy     <= 1'b1;
          end else begin
            rx_rst_n <= 1'b1;
            busy     <= 1'b0;
          end
        end

        ARM: begin
          if (!enable) begin
            state    <= IDLE;
            arm_cnt  <= '0;
            rx_rst_n <= 1'b1;
            busy     <= 1'b0;
          end else if (arm_cnt == ARM_LAST) begin
            state    <= WAIT;
            arm_cnt  <= '0;
            wait_cnt <= '0;
            rx_rst_n <= 1'b1;
          end else begin
            arm_cnt <= arm_cnt + 8'd1;
          end
        end

        WAIT: begin
          // enable has priority (partial frame dropped), then rx_done
          // beats a coincident watchdog expiry.
          if (!enable) begin
            state    <= IDLE;
            wait_cnt <= '0;
            busy     <= 1'b0;
          end else if (rx_done) begin
            state    <= CAPTURE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= ARM;
            wait_cnt    <= '0;
            arm_cnt     <= '0;
            rx_rst_n    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        CAPTURE: begin
          if (enable) begin
            state    <= ARM;
            arm_cnt  <= '0;
            rx_rst_n <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          rx_rst_n <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // 4-entry frame FIFO. A push at full is still taken when a pop happens
  // on the same clk, so the slot freed by the pop is reused.
  // ---------------------------------------------------------------------
  assign frame_valid = (count != 3'd0);
  assign frame_data  = frame_valid ? mem[rd_ptr] : '0;

  assign push_req = (state == CAPTURE) && accept;
  assign pop      = frame_valid && frame_ready;
  assign push     = push_req && ((count != 3'd4) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push_req && !push) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_ir_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ir_rx_ctrl
//   Directed bench for ir_rx_ctrl (ARM_CYCLES=4, TIMEOUT=100). Frames the
//   FIFO is expected to buffer are queued when issued; a negedge monitor
//   pops and compares whenever the consumer handshake fires.
// ---------------------------------------------------------------------------
module tb_ir_rx_ctrl;

`ifdef IR_RX_CTRL_MATCH_EN
  localparam bit MATCH_BUILD = 1'b1;
`else
  localparam bit MATCH_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        rx_done = 1'b0;
  logic [10:0] rx_data = '0;
  logic        frame_ready = 1'b0;
  logic        rx_rst_n;
  logic        frame_valid;
  logic [10:0] frame_data;
  logic        busy;
  logic        timeout_err;
  logic        overflow_err;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  int unsigned n_pops = 0;
  logic [10:0] sb [$];

  ir_rx_ctrl #(
    .ARM_CYCLES (4),
    .TIMEOUT    (100),
    .MATCH_CODE (11'h0F5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .rx_rst_n     (rx_rst_n),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_data   (frame_data),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: sampled mid-cycle, the handshake seen here is the
  // one the next rising edge consumes.
  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst && frame_valid && frame_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        check("unexpected_frame", {21'd0, frame_data}, 32'h7FF_FFFF);
      end else begin
        e = sb.pop_front();
        check("frame_pop", {21'd0, frame_data}, {21'd0, e});
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_rx_rst_n"},     {31'd0, rx_rst_n},     32'd0);
    check({tag, "_frame_valid"},  {31'd0, frame_valid},  32'd0);
    check({tag, "_frame_data"},   {21'd0, frame_data},   32'd0);
    check({tag, "_busy"},         {31'd0, busy},         32'd0);
    check({tag, "_timeout_err"},  {31'd0, timeout_err},  32'd0);
    check({tag, "_overflow_err"}, {31'd0, overflow_err}, 32'd0);
  endtask

  // Asserts rst between edges, checks the forced values, then releases.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    reset_checks(tag);
    sb.delete();
    enable      = 1'b0;
    rx_done     = 1'b0;
    frame_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check({tag, "_release_rx_rst_n"}, {31'd0, rx_rst_n}, 32'd1);
    check({tag, "_release_busy"},     {31'd0, busy},     32'd0);
  endtask

  task automatic wait_rearm();
    for (int b = 0; b < 20 && rx_rst_n == 1'b0; b++) tick();
    check("rearm_bound", {31'd0, rx_rst_n}, 32'd1);
  endtask

  // Counts clks with rx_rst_n low, starting from the first low sample.
  task automatic measure_arm(output int n);
    n = 0;
    for (int b = 0; b < 20 && rx_rst_n == 1'b0; b++) begin
      n++;
      tick();
    end
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick();
    check("arm_entered", {31'd0, rx_rst_n}, 32'd0);
    wait_rearm();
  endtask

  // Called in WAIT; returns once the block is back in WAIT.
  task automatic send_frame(input logic [10:0] v, input bit exp_push, input bit ready_cap);
    rx_data = v;
    rx_done = 1'b1;
    if (exp_push) sb.push_back(v);
    tick();
    rx_done     = 1'b0;
    frame_ready = ready_cap;
    tick();
    frame_ready = 1'b0;
    wait_rearm();
  endtask

  task automatic drain(input string tag);
    frame_ready = 1'b1;
    for (int b = 0; b < 50 && sb.size() != 0; b++) tick();
    frame_ready = 1'b0;
    check({tag, "_drain_done"},  sb.size(),             32'd0);
    check({tag, "_drain_empty"}, {31'd0, frame_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int k;
    int unsigned p0;
    logic [10:0] s5v [5];

    #1;
    do_reset("rst0");

    // Scenario 1: enable -> rx_rst_n low for exactly 4 clks, then WAIT
    enable = 1'b1;
    tick();
    check("s1_busy", {31'd0, busy}, 32'd1);
    measure_arm(n);
    check("s1_arm_len", n, 32'd4);
    check("s1_wait_rx_rst_n", {31'd0, rx_rst_n}, 32'd1);

    // Scenario 2: one frame with consumer ready, visible for exactly 1 clk
    rx_data     = 11'h0F5;
    rx_done     = 1'b1;
    frame_ready = 1'b1;
    sb.push_back(11'h0F5);
    tick();
    rx_done = 1'b0;
    tick();
    check("s2_valid",  {31'd0, frame_valid}, 32'd1);
    check("s2_rearm",  {31'd0, rx_rst_n},    32'd0);
    tick();
    check("s2_one_clk", {31'd0, frame_valid}, 32'd0);
    frame_ready = 1'b0;
    wait_rearm();

    // Scenario 3: watchdog fires on the 100th WAIT clk, then re-arms
    k = 0;
    while (timeout_err == 1'b0 && k < 300) begin
      tick();
      k++;
    end
    check("s3_timeout_clk", k, 32'd100);
    check("s3_timeout_err", {31'd0, timeout_err}, 32'd1);
    measure_arm(n);
    check("s3_arm_len", n, 32'd4);
    tick();
    check("s3_sticky", {31'd0, timeout_err}, 32'd1);
    wait_rearm();

    // Scenario 4: five frames with no consumer; fifth overflows
    for (int i = 1; i <= 5; i++)
      send_frame(11'(i), !MATCH_BUILD && (i <= 4), 1'b0);
    check("s4_valid",    {31'd0, frame_valid},  MATCH_BUILD ? 32'd0 : 32'd1);
    check("s4_head",     {21'd0, frame_data},   MATCH_BUILD ? 32'd0 : 32'd1);
    check("s4_overflow", {31'd0, overflow_err}, MATCH_BUILD ? 32'd0 : 32'd1);
    p0 = n_pops;
    drain("s4");
    check("s4_pop_count", n_pops - p0, MATCH_BUILD ? 32'd0 : 32'd4);

    // Scenario 5: full FIFO with a coincident push and pop
    do_reset("rst1");
    start_run();
    for (int i = 0; i < 5; i++) s5v[i] = MATCH_BUILD ? 11'h0F5 : 11'(6 + i);
    for (int i = 0; i < 4; i++) send_frame(s5v[i], 1'b1, 1'b0);
    check("s5_full_overflow", {31'd0, overflow_err}, 32'd0);
    p0 = n_pops;
    send_frame(s5v[4], 1'b1, 1'b1);
    check("s5_one_pop",  n_pops - p0,          32'd1);
    check("s5_overflow", {31'd0, overflow_err}, 32'd0);
    check("s5_head",     {21'd0, frame_data},   {21'd0, s5v[1]});
    p0 = n_pops;
    drain("s5");
    check("s5_pop_count", n_pops - p0, 32'd4);

    // Scenario 6: match filtering, then reset while waiting with data held
    send_frame(11'h0F5, 1'b1, 1'b0);
    send_frame(11'h123, !MATCH_BUILD, 1'b0);
    check("s6_head", {21'd0, frame_data}, 32'h0F5);
    p0 = n_pops;
    drain("s6");
    check("s6_pop_count", n_pops - p0, MATCH_BUILD ? 32'd1 : 32'd2);
    send_frame(11'h0F5, 1'b1, 1'b0);
    check("s6_held", {31'd0, frame_valid}, 32'd1);
    #2;
    do_reset("rst2");
    check("s6_discarded", {31'd0, frame_valid}, 32'd0);

    // enable falls in WAIT together with rx_done: frame dropped, back to IDLE
    start_run();
    enable  = 1'b0;
    rx_data = 11'h7FF;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    check("en_fall_busy", {31'd0, busy}, 32'd0);
    tick();
    check("en_fall_no_frame", {31'd0, frame_valid}, 32'd0);
    check("en_fall_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1);
  end

endmodule

// File: doc/ir_rx_ctrl.md
IR_RX_CTRL -- requirements
Module: ir_rx_ctrl

Interface
REQ-001 Parameter: ARM_CYCLES, 4, cycles the receiver reset is held low per arm (range 1..255).
REQ-002 Parameter: TIMEOUT, 1200000, WAIT-state watchdog limit in clk cycles (32-bit counter).
REQ-003 Parameter: MATCH_CODE, 11'b00011110101, accepted frame code when match filtering is compiled in.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 enable  in  1  1 = run receive cycles; 0 = stop after the current state returns to IDLE.
REQ-007 rx_done  in  1  receive-status level from the IR receiver; high when 11 bits have been received.
REQ-008 rx_data  in  11  received frame from the IR receiver.
REQ-009 rx_rst_n  out  1  active-low restart to the IR receiver; low = receiver held in reset.
REQ-010 frame_valid  out  1  FIFO head frame is available.
REQ-011 frame_ready  in  1  consumer accepts the head frame when it is high together with frame_valid.
REQ-012 frame_data  out  11  FIFO head frame.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 timeout_err  out  1  sticky; set on watchdog expiry; cleared only by rst.
REQ-015 overflow_err  out  1  sticky; set when a frame is dropped because the FIFO is full; cleared only by rst.

Function
REQ-016 The block SHALL implement the states IDLE, ARM, WAIT and CAPTURE, with one transition per clk at most.
REQ-017 In IDLE with enable=1, the block SHALL go to ARM on the next clk; with enable=0 it SHALL stay in IDLE.
REQ-018 ARM SHALL drive rx_rst_n=0 for exactly ARM_CYCLES clks, then go to WAIT; rx_rst_n SHALL be 1 in all other states.
REQ-019 WAIT SHALL count clks from 0; rx_done=1 SHALL cause a transition to CAPTURE on the next clk.
REQ-020 If the WAIT count reaches TIMEOUT-1 with rx_done=0, the block SHALL set timeout_err and go to ARM.
REQ-021 If rx_done=1 and the timeout occur on the same clk, rx_done SHALL win: go to CAPTURE and leave timeout_err unchanged.
REQ-022 CAPTURE SHALL last one clk, push rx_data into the FIFO if the frame is accepted, then go to ARM if enable=1, else to IDLE.
REQ-023 If enable falls during ARM or WAIT, the block SHALL return to IDLE on the next clk and drop any partial frame.
REQ-024 The FIFO SHALL hold 4 entries of 11 bits, with 2-bit wrapping pointers and a 3-bit count.
REQ-025 frame_valid SHALL equal (count != 0); frame_data SHALL be the head entry, with no extra latency.
REQ-026 A frame pushed on clk N SHALL appear at frame_valid/frame_data after clk N when the FIFO was empty.
REQ-027 A push and a pop on the same clk SHALL both occur, with the count unchanged; this SHALL also apply when the count is 4.
REQ-028 A push when count=4 without a pop SHALL discard the frame and set overflow_err.

Reset
REQ-029 rst=1 SHALL asynchronously force state=IDLE, all counters=0, FIFO empty, rx_rst_n=0, frame_valid=0, frame_data=0, busy=0, timeout_err=0 and overflow_err=0.
REQ-030 After rst deasserts, rx_rst_n SHALL go to 1 on the first clk.
REQ-031 Reset asserted mid-operation SHALL discard all buffered frames.

Configuration
REQ-032 Macro IR_RX_CTRL_MATCH_EN defined: CAPTURE SHALL push only when rx_data==MATCH_CODE; non-matching frames SHALL be dropped silently and the block SHALL re-arm.
REQ-033 Macro IR_RX_CTRL_MATCH_EN undefined: every captured frame SHALL be pushed, and MATCH_CODE SHALL be unused.

Verification
REQ-034 Scenario 1 (ARM_CYCLES=4): rst, then enable=1 -> rx_rst_n low for exactly 4 clks, then state WAIT.
REQ-035 Scenario 2: in WAIT, rx_done=1 with rx_data=11'h0F5, frame_ready=1 -> frame_valid high for 1 clk with frame_data=11'h0F5, then re-ARM.
REQ-036 Scenario 3 (TIMEOUT=100): rx_done held 0 -> timeout_err=1 at WAIT clk 100, then rx_rst_n low 4 clks.
REQ-037 Scenario 4: frame_ready=0, 5 frames 1..5 -> FIFO holds 1..4 and overflow_err=1; draining yields 1,2,3,4 in order.
REQ-038 Scenario 5: FIFO full with a simultaneous push and pop -> count stays 4, overflow_err stays 0, order is preserved.
REQ-039 Scenario 6: with IR_RX_CTRL_MATCH_EN defined, frames 11'h0F5 and 11'h123 -> only 11'h0F5 is output; rst asserted in WAIT -> all outputs go to their reset values immediately.
